ram_cmd_arbiter: RTL and testbench

Two-port command arbiter that shares the single-port command RAM between two 10-bit command requesters, such as the SPI slave and a local host port. It serializes their command words onto the RAM's `rx_valid`/`din` interface. It keeps address/data command pairs atomic so one requester cannot overwrite the RAM's latched write or read address mid-transaction. It routes read data back to the requester that issued the read.

---
 rtl/ram_cmd_arbiter.sv | 154 +++++++++++++++
 tb/tb_ram_cmd_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_cmd_arbiter.sv
// Two-requester arbiter in front of the single-port command RAM. It keeps address/data
// command pairs atomic and returns read data to the requester that issued the read.
module ram_cmd_arbiter #(
  parameter int unsigned ADDR_SIZE    = 8,
  parameter int unsigned LOCK_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 req0_valid,
  input  logic [ADDR_SIZE+1:0] req0_din,
  output logic                 req0_ready,
  output logic                 rsp0_valid,
  output logic [ADDR_SIZE-1:0] rsp0_data,

  input  logic                 req1_valid,
  input  logic [ADDR_SIZE+1:0] req1_din,
  output logic                 req1_ready,
  output logic                 rsp1_valid,
  output logic [ADDR_SIZE-1:0] rsp1_data,

  output logic                 ram_rx_valid,
  output logic [ADDR_SIZE+1:0] ram_din,
  input  logic [ADDR_SIZE+1:0] ram_dout,
  input  logic                 ram_tx_valid,

  output logic                 locked,
  output logic                 lock_owner,
  output logic                 timeout_err
);

  localparam int unsigned CW = ADDR_SIZE + 2;

  typedef enum logic [1:0] {StIdle, StLocked, StReadWait} state_e;

  state_e     state_q;
  logic       rr_q;
  logic       owner_q;
  logic       rd_owner_q;
  logic       rw_phase_q;
  logic [7:0] cnt_q;

  logic          acc0;
  logic          acc1;
  logic          acc;
  logic          acc_id;
  logic [CW-1:0] acc_din;
  logic [1:0]    acc_op;

  // Read data comes back by fixed latency, so the RAM's strobe and opcode bits are not needed.
  logic unused_ram_bits;
  assign unused_ram_bits = ^{ram_tx_valid, ram_dout[CW-1:ADDR_SIZE]};

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      StIdle: begin
        if (req0_valid && req1_valid) begin
          req0_ready = ~rr_q;
          req1_ready = rr_q;
        end else begin
          req0_ready = req0_valid;
          req1_ready = req1_valid;
        end
      end
      StLocked: begin
        req0_ready = ~owner_q;
        req1_ready = owner_q;
      end
      default: ;
    endcase
  end

  assign acc0    = req0_valid & req0_ready;
  assign acc1    = req1_valid & req1_ready;
  assign acc     = acc0 | acc1;
  assign acc_id  = acc1;
  assign acc_din = acc1 ? req1_din : req0_din;
  assign acc_op  = acc_din[CW-1 -: 2];

  assign locked     = (state_q == StLocked);
  assign lock_owner = locked & owner_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_q         <= 1'b0;
      owner_q      <= 1'b0;
      rd_owner_q   <= 1'b0;
      rw_phase_q   <= 1'b0;
      cnt_q        <= 8'd0;
      ram_rx_valid <= 1'b0;
      ram_din      <= '0;
      timeout_err  <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp0_data    <= '0;
      rsp1_data    <= '0;
    end else begin
      ram_rx_valid <= acc;
      if (acc) ram_din <= acc_din;
      timeout_err <= 1'b0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;

      if (acc) begin
        if (state_q == StIdle) rr_q <= ~acc_id;
        case (acc_op)
          2'b00, 2'b10: begin
            state_q <= StLocked;
            owner_q <= acc_id;
            cnt_q   <= 8'd0;
          end
          2'b01: state_q <= StIdle;
          default: begin
            state_q    <= StReadWait;
            rd_owner_q <= acc_id;
            rw_phase_q <= 1'b0;
          end
        endcase
      end else begin
        case (state_q)
          StLocked: begin
            if (cnt_q == 8'(LOCK_TIMEOUT - 1)) begin
              // Owner went quiet: release and give the other side first pick.
              state_q     <= StIdle;
              timeout_err <= 1'b1;
              rr_q        <= ~owner_q;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          StReadWait: begin
            if (rw_phase_q) begin
              state_q <= StIdle;
              if (rd_owner_q) begin
                rsp1_valid <= 1'b1;
                rsp1_data  <= ram_dout[ADDR_SIZE-1:0];
              end else begin
                rsp0_valid <= 1'b1;
                rsp0_data  <= ram_dout[ADDR_SIZE-1:0];
              end
            end else begin
              rw_phase_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Self-checking bench for ram_cmd_arbiter: deadline-based reference model plus directed
// scenarios and randomized traffic against a behavioural command RAM.
module tb_ram_cmd_arbiter;

  localparam int LT = 15;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [9:0] req0_din, req1_din;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_data, rsp1_data;
  logic       ram_rx_valid;
  logic [9:0] ram_din;
  logic [9:0] ram_dout;
  logic       ram_tx_valid;
  logic       locked, lock_owner, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  ram_cmd_arbiter #(.ADDR_SIZE(8), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_din(req0_din), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_din(req1_din), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .ram_rx_valid(ram_rx_valid), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_tx_valid(ram_tx_valid),
    .locked(locked), .lock_owner(lock_owner), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural command RAM: read data is only meaningful in the cycle after the read strobe.
  logic [7:0] env_mem [256];
  logic [7:0] env_waddr, env_raddr;
  always @(posedge clk) begin
    ram_dout <= 10'($urandom);
    ram_tx_valid <= 1'b0;
    if (ram_rx_valid === 1'b1) begin
      case (ram_din[9:8])
        2'b00: env_waddr <= ram_din[7:0];
        2'b01: env_mem[env_waddr] <= ram_din[7:0];
        2'b10: env_raddr <= ram_din[7:0];
        default: begin
          ram_dout     <= {2'b11, env_mem[env_raddr]};
          ram_tx_valid <= 1'b1;
        end
      endcase
    end
  end

  // Reference model: lock/busy expressed as absolute-cycle deadlines.
  int         cyc = 0;
  bit         m_lock, m_own, m_rr, m_who, m_pacc, m_acc0, m_acc1;
  int         m_expire, m_busy, m_due;
  logic [7:0] m_pdata, m_rdata0, m_rdata1;
  logic [9:0] m_pdin;
  logic [7:0] mm [256];
  logic [7:0] mw, mr;

  task automatic m_reset();
    m_lock = 0; m_own = 0; m_rr = 0; m_who = 0; m_pacc = 0;
    m_acc0 = 0; m_acc1 = 0;
    m_expire = 0; m_busy = 0; m_due = -1;
    m_pdata = 8'h00; m_rdata0 = 8'h00; m_rdata1 = 8'h00; m_pdin = 10'h000;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs after the edge, check and advance the model at the negedge.
  task automatic step(input bit v0, input logic [9:0] d0, input bit v1, input logic [9:0] d1,
                      input bit rst = 0, input bit cmp = 1);
    bit         e_tmo, e_r0, e_r1, e_rv0, e_rv1, was_locked, id;
    logic [9:0] d;
    @(posedge clk);
    #1;
    rst_n = ~rst;
    req0_valid = v0; req0_din = d0;
    req1_valid = v1; req1_din = d1;
    @(negedge clk);
    e_tmo = 0;
    if (m_lock && cyc == m_expire) begin
      m_lock = 0; e_tmo = 1; m_rr = ~m_own;
    end
    e_r0 = 0; e_r1 = 0;
    if (cyc < m_busy) begin
      e_r0 = 0; e_r1 = 0;
    end else if (m_lock) begin
      e_r0 = ~m_own; e_r1 = m_own;
    end else if (v0 && v1) begin
      e_r0 = ~m_rr; e_r1 = m_rr;
    end else begin
      e_r0 = v0; e_r1 = v1;
    end
    e_rv0 = (cyc == m_due) && !m_who;
    e_rv1 = (cyc == m_due) && m_who;
    if (e_rv0) m_rdata0 = m_pdata;
    if (e_rv1) m_rdata1 = m_pdata;
    if (cmp) begin
      chk("req0_ready", 32'(req0_ready), 32'(e_r0));
      chk("req1_ready", 32'(req1_ready), 32'(e_r1));
      chk("ram_rx_valid", 32'(ram_rx_valid), 32'(m_pacc));
      if (m_pacc) chk("ram_din", 32'(ram_din), 32'(m_pdin));
      chk("locked", 32'(locked), 32'(m_lock));
      chk("lock_owner", 32'(lock_owner), 32'(m_lock & m_own));
      chk("timeout_err", 32'(timeout_err), 32'(e_tmo));
      chk("rsp0_valid", 32'(rsp0_valid), 32'(e_rv0));
      chk("rsp1_valid", 32'(rsp1_valid), 32'(e_rv1));
      chk("rsp0_data", 32'(rsp0_data), 32'(m_rdata0));
      chk("rsp1_data", 32'(rsp1_data), 32'(m_rdata1));
    end
    if (rst) begin
      m_reset();
    end else begin
      was_locked = m_lock;
      m_acc0 = v0 && e_r0;
      m_acc1 = v1 && e_r1;
      m_pacc = m_acc0 || m_acc1;
      if (m_pacc) begin
        id = m_acc1;
        d = m_acc1 ? d1 : d0;
        m_pdin = d;
        case (d[9:8])
          2'b00, 2'b10: begin
            if (d[9]) mr = d[7:0]; else mw = d[7:0];
            m_lock = 1; m_own = id; m_expire = cyc + 1 + LT;
          end
          2'b01: begin
            mm[mw] = d[7:0]; m_lock = 0;
          end
          default: begin
            m_lock = 0; m_busy = cyc + 3; m_due = cyc + 3; m_who = id; m_pdata = mm[mr];
          end
        endcase
        if (!was_locked) m_rr = ~id;
      end
    end
    cyc++;
  endtask

  function automatic logic [9:0] gen_cmd();
    logic [1:0] op;
    op = 2'($urandom_range(3));
    if (op == 2'b01) return {op, 8'($urandom)};
    return {op, 8'($urandom_range(7))};
  endfunction

  bit         pv0, pv1;
  logic [9:0] pd0, pd1;
  int         rate0, rate1;
  int         rates [4] = '{3, 30, 70, 100};

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 8'(i * 7 + 3);
      mm[i]      = 8'(i * 7 + 3);
    end
    env_waddr = 8'h00; env_raddr = 8'h00; mw = 8'h00; mr = 8'h00;
    ram_dout = 10'h000; ram_tx_valid = 1'b0;
    rst_n = 1'b0;
    req0_valid = 0; req0_din = 10'h000; req1_valid = 0; req1_din = 10'h000;
    m_reset();
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // Reset state and a locked write pair from req0.
    step(0, 0, 0, 0);
    chk("rst_rx_valid", 32'(ram_rx_valid), 0);
    chk("rst_din", 32'(ram_din), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_rsp_data", 32'({rsp0_data, rsp1_data}), 0);
    step(1, 10'h005, 0, 0);
    chk("t1_ready0", 32'(req0_ready), 1);
    step(1, 10'h1AB, 0, 0);
    chk("t1_din_addr", 32'(ram_din), 32'h005);
    chk("t1_locked", 32'(locked), 1);
    chk("t1_owner", 32'(lock_owner), 0);
    step(0, 0, 0, 0);
    chk("t1_din_data", 32'(ram_din), 32'h1AB);
    chk("t1_unlocked", 32'(locked), 0);

    // Contention, lock stall of the non-owner, round-robin return to req0.
    step(0, 0, 0, 0, 1);
    step(1, 10'h005, 1, 10'h0FF);
    chk("t2_g0_r0", 32'(req0_ready), 1);
    chk("t2_g0_r1", 32'(req1_ready), 0);
    step(1, 10'h1AB, 1, 10'h0FF);
    chk("t2_stall_r1", 32'(req1_ready), 0);
    chk("t2_seq0", 32'(ram_din), 32'h005);
    step(1, 10'h00A, 1, 10'h0FF);
    chk("t2_g1_r1", 32'(req1_ready), 1);
    chk("t2_g1_r0", 32'(req0_ready), 0);
    chk("t2_seq1", 32'(ram_din), 32'h1AB);
    step(1, 10'h00A, 1, 10'h1CD);
    chk("t2_seq2", 32'(ram_din), 32'h0FF);
    chk("t2_owner1", 32'(lock_owner), 1);
    step(1, 10'h00A, 1, 10'h0EE);
    chk("t2_g2_r0", 32'(req0_ready), 1);
    chk("t2_g2_r1", 32'(req1_ready), 0);
    step(1, 10'h1AB, 0, 0);

    // Read routed back to req1, no accepts during the read wait.
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 10'h005);
    step(0, 0, 1, 10'h1AB);
    step(0, 0, 1, 10'h205);
    step(0, 0, 1, 10'h300);
    chk("t4_acc_read", 32'(req1_ready), 1);
    step(1, 10'h1CD, 1, 10'h1EE);
    chk("t4_wait1", 32'({req0_ready, req1_ready}), 0);
    chk("t4_din", 32'(ram_din), 32'h300);
    step(1, 10'h1CD, 1, 10'h1EE);
    chk("t4_wait2", 32'({req0_ready, req1_ready}), 0);
    step(1, 10'h1CD, 0, 0);
    chk("t4_rsp1_valid", 32'(rsp1_valid), 1);
    chk("t4_rsp1_data", 32'(rsp1_data), 32'hAB);
    chk("t4_rsp0_valid", 32'(rsp0_valid), 0);
    chk("t4_next_acc", 32'(req0_ready), 1);
    step(0, 0, 0, 0);
    chk("t4_hold", 32'(rsp1_data), 32'hAB);

    // Reset in the cycle after a read accept drops the response.
    step(1, 10'h205, 0, 0);
    step(1, 10'h300, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("t6_outs", 32'({ram_rx_valid, locked, lock_owner, timeout_err, rsp0_valid,
                        rsp1_valid}), 0);
    chk("t6_data", 32'({ram_din, rsp0_data, rsp1_data}), 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0);
      chk("t6_no_rsp", 32'({rsp0_valid, rsp1_valid}), 0);
    end

    // Lock timeout: req0 goes silent, req1 waits and is served in the timeout cycle.
    step(0, 0, 0, 0, 1);
    step(1, 10'h005, 0, 0);
    for (int k = 1; k <= LT + 1; k++) begin
      step(0, 0, 1, 10'h1EE);
      chk("t5_tmo", 32'(timeout_err), 32'(k == LT + 1));
      chk("t5_ready1", 32'(req1_ready), 32'(k == LT + 1));
    end
    step(0, 0, 0, 0);
    chk("t5_din", 32'(ram_din), 32'h1EE);

    // Randomized traffic; pending commands stay presented until accepted.
    step(0, 0, 0, 0, 1);
    pv0 = 0; pv1 = 0; pd0 = 10'h000; pd1 = 10'h000;
    for (int ph = 0; ph < 15; ph++) begin
      rate0 = rates[$urandom_range(3)];
      rate1 = rates[$urandom_range(3)];
      for (int k = 0; k < 200; k++) begin
        if (!pv0 && $urandom_range(99) < rate0) begin pv0 = 1; pd0 = gen_cmd(); end
        if (!pv1 && $urandom_range(99) < rate1) begin pv1 = 1; pd1 = gen_cmd(); end
        if ($urandom_range(999) < 3) begin
          step(pv0, pd0, pv1, pd1, 1);
        end else begin
          step(pv0, pd0, pv1, pd1);
          if (m_acc0) pv0 = 0;
          if (m_acc1) pv1 = 0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
